shift_unit: RTL
===============

// Module: shift_unit
// PURPOSE
//   Parametrised sequential shift/rotate unit; successor to the 8-bit serial-in shifter.
//   Executes one command (load, logical/arithmetic shift, rotate, serial-in) over a programmable step count.
//   Steps one bit per clock under a Start/Busy/Done handshake; Dout drives board LEDs/hex via top.
// PARAMETERS
//   WIDTH  8             data width, >= 2
//   AW     $clog2(WIDTH) Amt width (derived, do not override)
//   TAPS   8'b0001_1101  LFSR feedback mask, WIDTH bits (only used with SHIFT_UNIT_LFSR_EN)
// PORTS
//   Clk       in   1      clock, all state on rising edge
//   Rst_n     in   1      asynchronous active-low reset
//   Start     in   1      command request; accepted only when Busy=0
//   Op        in   3      command code, sampled with Start
//   Amt       in   AW     step count 0..WIDTH-1, sampled with Start
//   Load_val  in   WIDTH  parallel load value (Op=LOAD)
//   Din       in   1      serial input, sampled on every SIN step
//   Dout      out  WIDTH  shift register contents
//   Busy      out  1      command in progress
//   Done      out  1      one-cycle completion pulse
// BEHAVIOUR
//   Reset (async, Rst_n=0): Dout=0, Busy=0, Done=0, state=IDLE, count=0; takes effect immediately, aborts any command.
//   Op codes: 000 LOAD; 001 SLL (fill 0); 010 SRL (fill 0); 011 SRA (fill Dout[MSB]);
//             100 ROL; 101 ROR; 110 SIN (shift right, MSB<=Din); 111 LFSR (optional, see below).
//   FSM IDLE/SHIFT. Busy = (state==SHIFT). Done defaults to 0 every cycle.
//   IDLE, Start=1 at edge T0:
//     LOAD               -> Dout<=Load_val, Done<=1, stay IDLE (Amt ignored).
//     shift op, Amt=0    -> Dout unchanged, Done<=1, stay IDLE.
//     shift op, Amt=N>0  -> latch Op, count<=N, state<=SHIFT; Dout unchanged at T0.
//   SHIFT, each edge: apply one step of latched Op, count<=count-1;
//     step with count==1 -> state<=IDLE, Done<=1 on same edge.
//   Latency: N>0 -> Busy high T0..T(N), Done=1 after edge T(N), N steps applied; LOAD/N=0 -> Done after T0.
//   Start while Busy: ignored, no queueing; Op/Amt/Load_val changes while Busy have no effect.
//   Start in the cycle Done=1 (state IDLE): accepted normally (back-to-back allowed).
//   Din is sampled at each SIN step edge, not latched at Start.
//   Rotates are lossless; shifts discard bits leaving the register.
// CONFIGURATION
//   SHIFT_UNIT_LFSR_EN defined: Op=111 is LFSR, each step Dout <= {^(Dout & TAPS), Dout[WIDTH-1:1]};
//     LFSR state 0 stays 0 (no lockup recovery).
//   Not defined: Op=111 treated as Amt=0 regardless of Amt: Done<=1 after T0, Dout unchanged, Busy stays 0.
// TESTING (WIDTH=8)
//   1 Rst_n low mid-SHIFT (after 2 of 5 steps) -> Dout=8'h00, Busy=0, Done=0 before next Clk edge; restart works.
//   2 LOAD 8'hB4 then SRA Amt=3 -> Busy high 4 cycles (T0..T3), Done after T3, Dout=8'hF6.
//   3 LOAD 8'h81 then ROL Amt=7 -> Dout=8'hC0; ROR Amt=1 from 8'h81 -> 8'hC0.
//   4 LOAD 8'h00, SIN Amt=4, Din=1 held -> Dout=8'hF0; SLL Amt=3 from 8'hFF -> 8'hF8.
//   5 Start (SLL Amt=2) while Busy -> ignored, result of first command only; Amt=0 -> Done after T0, Dout unchanged.
//   6 LFSR_EN: LOAD 8'h01, LFSR Amt=2 -> 8'h80 then 8'h40; without macro Op=111 -> Done after T0, Dout=8'h01.

Source files
------------

// File: rtl/shift_unit.sv
// shift_unit: sequential shift/rotate unit, one bit per clock under a Start/Busy/Done handshake.
// Optional LFSR command (Op=111) is built in when SHIFT_UNIT_LFSR_EN is defined.
module shift_unit #(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      AW    = $clog2(WIDTH),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'b0001_1101)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [AW-1:0]    Amt,
  input  logic [WIDTH-1:0] Load_val,
  input  logic             Din,
  output logic [WIDTH-1:0] Dout,
  output logic             Busy,
  output logic             Done
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_SIN  = 3'b110;
  localparam logic [2:0] OP_LFSR = 3'b111;

`ifdef SHIFT_UNIT_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             no_step_c;

  // One step of the latched command applied to the current register value.
  function automatic logic [WIDTH-1:0] step_fn(input logic [2:0]       op,
                                               input logic [WIDTH-1:0] d,
                                               input logic             din);
    logic [WIDTH-1:0] r;
    r = d;
    case (op)
      OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, d[WIDTH-1:1]};
      OP_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      OP_ROR:  r = {d[0], d[WIDTH-1:1]};
      OP_SIN:  r = {din, d[WIDTH-1:1]};
      OP_LFSR: r = LFSR_EN ? {^(d & TAPS), d[WIDTH-1:1]} : d;
      default: r = d;
    endcase
    return r;
  endfunction

  // Commands that complete at the accepting edge without entering SHIFT.
  assign no_step_c = (Amt == '0) || ((Op == OP_LFSR) && !LFSR_EN);

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (Op == OP_LOAD) begin
            dout_d = Load_val;
            done_d = 1'b1;
          end else if (no_step_c) begin
            done_d = 1'b1;
          end else begin
            op_d    = Op;
            count_d = Amt;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        dout_d  = step_fn(op_q, dout_q, Din);
        count_d = count_q - AW'(1);
        if (count_q == AW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      count_q <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Dout = dout_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule
